// File: rtl/pwm_pkg.sv
// Shared constants and types for the 16-channel PWM output stage.
package pwm_pkg;
  localparam int CH_N = 16;
  localparam int DUTY_W = 8;
  localparam logic [DUTY_W-1:0] DUTY_FULL = 8'hFF;

  typedef logic [CH_N-1:0] ch_vec_t;
endpackage

// File: rtl/pwm_timebase.sv
// Prescaler plus 8-bit period counter; one PWM period is 256 ticks of DIV clks each.
module pwm_timebase #(
  parameter int DIV = 13
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic       tick,
  output logic [7:0] cnt,
  output logic       wrap
);
  localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(DIV - 1);

  logic [PRE_W-1:0] pre;

  // With DIV=1 pre never leaves 0, so tick stays high every cycle.
  assign tick = (pre == PRE_MAX);
  assign wrap = tick && (cnt == 8'hFF);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre <= '0;
      cnt <= '0;
    end else if (tick) begin
      pre <= '0;
      cnt <= cnt + 8'd1;
    end else begin
      pre <= pre + PRE_W'(1);
    end
  end
endmodule

// File: rtl/pwm_peripheral.sv
// Sixteen-channel PWM output stage: duty compare, per-channel gating, registered pins.
// Optional PWM_DUTY_SHADOW_EN: duty is latched only at period start for glitch-free periods.
module pwm_peripheral
  import pwm_pkg::*;
#(
  parameter int DIV = 13
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  en_reg_out_7_0,
  input  logic [7:0]  en_reg_out_15_8,
  input  logic [7:0]  en_reg_pwm_7_0,
  input  logic [7:0]  en_reg_pwm_15_8,
  input  logic [7:0]  pwm_duty_cycle,
  output logic [15:0] out,
  output logic        period_start
);
  logic              tick_unused;
  logic [7:0]        cnt;
  logic              wrap;
  logic [DUTY_W-1:0] duty_act;
  logic              pwm_raw;
  ch_vec_t           en_out;
  ch_vec_t           en_pwm;
  ch_vec_t           next_out;

  pwm_timebase #(.DIV(DIV)) u_timebase (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick_unused),
    .cnt   (cnt),
    .wrap  (wrap)
  );

  assign en_out = {en_reg_out_15_8, en_reg_out_7_0};
  assign en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};

`ifdef PWM_DUTY_SHADOW_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_act <= '0;
    end else if (wrap) begin
      duty_act <= pwm_duty_cycle;
    end
  end
`else
  assign duty_act = pwm_duty_cycle;
`endif

  // Full-scale duty must hold high through cnt=255, which a plain compare cannot reach.
  assign pwm_raw = (duty_act == DUTY_FULL) || (cnt < duty_act);

  always_comb begin
    next_out = '0;
    for (int i = 0; i < CH_N; i++) begin
      next_out[i] = en_out[i] & (~en_pwm[i] | pwm_raw);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out          <= '0;
      period_start <= 1'b0;
    end else begin
      out          <= next_out;
      period_start <= wrap;
    end
  end
endmodule

// File: doc/pwm_peripheral.md
# pwm_peripheral

Sixteen-channel PWM output stage that sits directly downstream of the SPI register block. It consumes the five configuration bytes that block holds (output enables, PWM-mode enables, shared duty cycle) and drives the 16 physical output pins. A prescaler and an 8-bit period counter generate one shared PWM waveform, and each channel is gated to off, static high or PWM.

## Interface
Parameters:
- DIV, 13: clk cycles per PWM tick; legal range ≥1. The default gives ≈3 kHz PWM at a 10 MHz clk (10 MHz / 13 / 256).

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- en_reg_out_7_0  in  8  output enable, channels 7..0
- en_reg_out_15_8  in  8  output enable, channels 15..8
- en_reg_pwm_7_0  in  8  PWM-mode enable, channels 7..0
- en_reg_pwm_15_8  in  8  PWM-mode enable, channels 15..8
- pwm_duty_cycle  in  8  shared duty value, 0x00..0xFF
- out  out  16  registered channel outputs
- period_start  out  1  one-cycle pulse on the clk where cnt becomes 0

All inputs are synchronous to clk and are sampled every cycle.

## Operation
- **Prescaler**
  - `pre`, width $clog2(DIV) (min 1), counts 0..DIV-1.
  - `tick` = (pre == DIV-1); on tick, pre → 0.
  - DIV=1: tick is asserted every cycle.
- **Period counter**
  - `cnt`, 8 bits, advances only on tick.
  - Wraps 255 → 0; period is 256 ticks = 256·DIV cycles.
- **Duty compare** (uses duty_act, the active duty value)
  - duty_act == 0xFF → pwm_raw = 1 constantly.
  - Otherwise pwm_raw = (cnt < duty_act).
  - 0x00 → always low; 0x80 → high for 128 of 256 ticks.
- **Per-channel select** (i = 0..15, en_out/en_pwm are the concatenated 16-bit enables)
  - next_out[i] = en_out[i] ? (en_pwm[i] ? pwm_raw : 1) : 0.
  - en_pwm is ignored when en_out is 0.
- **Registering**
  - out <= next_out every clk.
  - period_start <= (tick && cnt == 255).
- **Enables:** enable changes are never deferred; they reach out one clk after the input changes.

## Timing
- **Reset values:** pre=0, cnt=0, duty_act=0x00, out=16'h0000, period_start=0.
- **Reset release:** first tick occurs DIV cycles after the first active clk.
- **Latency:** input/counter state in cycle n appears on out in cycle n+1, with no further pipeline.
- **Waveform shape:** out for a PWM channel rises on the cycle after cnt wraps to 0. It falls on the cycle after cnt reaches duty_act.
- **Edge cases:**
  - A duty change to the value equal to the current cnt deasserts pwm_raw immediately (in unshadowed mode).
  - A change to 0xFF asserts it immediately (in unshadowed mode).
- **Reset mid-period:** all state returns to reset values asynchronously, and out drops to 0 without waiting for clk.
- **No handshake:** there is no back-pressure and no valid strobe; inputs are level registers.

## Configuration
- PWM_DUTY_SHADOW_EN defined:
  - duty_act is a register, loaded from pwm_duty_cycle only on the clk where tick && cnt == 255, i.e. together with the period_start pulse.
  - A mid-period duty write therefore takes effect at the next period start, which guarantees glitch-free periods.
- Undefined:
  - duty_act = pwm_duty_cycle combinationally; duty changes affect the current period.
  - The shadow register is not instantiated.

## Structure
- Package pwm_pkg:
  - CH_N = 16, DUTY_W = 8, DUTY_FULL = 8'hFF.
  - typedef logic [CH_N-1:0] ch_vec_t.
- Sub-module pwm_timebase:
  - Contains the prescaler and period counter, parameter DIV.
  - Outputs tick, cnt[7:0] and wrap (tick && cnt==255).
- pwm_peripheral contains the duty shadow, compare, channel select and output registers.

## Test plan
- **Reset:** assert rst_n=0 mid-run with all enables 0xFF and duty 0x80 → out=0x0000 and period_start=0 immediately; after release, the first tick comes after DIV clks.
- **50% duty:** en_out=0xFFFF, en_pwm=0xFFFF, duty=0x80, DIV=13 → out=0xFFFF for 128·13 clks, then 0x0000 for 128·13 clks; period 3328 clks; period_start pulses once per period.
- **Extremes:** duty=0x00 → out stays 0x0000 for ≥2 periods; duty=0xFF → out stays 0xFFFF for ≥2 periods.
- **Mixed modes:** en_out=0x00F0, en_pwm=0x0030, duty=0x40 → bits 5:4 are PWM at 64/256, bits 7:6 are constant 1, all others 0.
- **Shadow:** with PWM_DUTY_SHADOW_EN, change duty 0x20→0xC0 at cnt=0x50 → the current period stays low from 0x20 onward, and the next period is high for 192 ticks. Without the macro, out re-asserts on the following clk.
- **DIV=1:** duty=0x01 → out high for exactly 1 clk in every 256.
